// File: rtl/ysyx_25040109_lsu.sv
// Load/store unit: one transaction in flight, sitting between execute and write-back.
// Formats store masks/data on the way out and aligns/extends load data on the way back.
module ysyx_25040109_lsu (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_mem_ren,
   input  logic        in_mem_wen,
   input  logic [2:0]  in_funct3,
   input  logic [31:0] in_result,
   input  logic [31:0] in_wdata,
   input  logic [4:0]  in_rd_addr,
   input  logic        in_reg_write,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_wb_data,
   output logic [4:0]  out_rd_addr,
   output logic        out_reg_write,
   output logic        out_misalign,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   output logic        mem_req_wen,
   output logic [31:0] mem_req_wdata,
   output logic [3:0]  mem_req_wmask,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic [2:0]  funct3_q;
   logic [4:0]  rd_q;
   logic        regw_q, load_q, store_q, mis_q;

   // Both enables set counts as a store; funct3[1] alone marks a word access.
   logic in_store, in_load, in_mis, accept;
   assign in_store = in_mem_wen;
   assign in_load  = in_mem_ren & ~in_mem_wen;
   assign in_mis   = (in_store | in_load) &
                     (((in_funct3[1:0] == 2'b01) & in_result[0]) |
                      (in_funct3[1] & (|in_result[1:0])));
   assign accept   = in_valid & (state_q == S_IDLE);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (in_valid) state_d = ((in_store | in_load) & ~in_mis) ? S_REQ : S_DONE;
         S_REQ:  if (mem_req_ready) state_d = S_WAIT;
         S_WAIT: if (mem_rsp_valid) state_d = S_DONE;
         S_DONE: if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         funct3_q <= '0;
         rd_q     <= '0;
         regw_q   <= 1'b0;
         load_q   <= 1'b0;
         store_q  <= 1'b0;
         mis_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q   <= in_result;
            wdata_q  <= in_wdata;
            funct3_q <= in_funct3;
            rd_q     <= in_rd_addr;
            regw_q   <= in_reg_write;
            load_q   <= in_load;
            store_q  <= in_store;
            mis_q    <= in_mis;
         end
         if (state_q == S_WAIT && mem_rsp_valid) rdata_q <= mem_rsp_rdata;
      end
   end

   logic [31:0] rshift, load_fmt;
   assign rshift = rdata_q >> {addr_q[1:0], 3'b000};

   always_comb begin
      unique case (funct3_q)
         3'b000:  load_fmt = {{24{rshift[7]}}, rshift[7:0]};
         3'b001:  load_fmt = {{16{rshift[15]}}, rshift[15:0]};
         3'b100:  load_fmt = {24'd0, rshift[7:0]};
         3'b101:  load_fmt = {16'd0, rshift[15:0]};
         default: load_fmt = rshift;
      endcase
   end

   always_comb begin
      mem_req_wmask = 4'b0000;
      unique case (funct3_q[1:0])
         2'b00:   mem_req_wdata = {4{wdata_q[7:0]}};
         2'b01:   mem_req_wdata = {2{wdata_q[15:0]}};
         default: mem_req_wdata = wdata_q;
      endcase
      if (store_q) begin
         unique case (funct3_q[1:0])
            2'b00:   mem_req_wmask = 4'b0001 << addr_q[1:0];
            2'b01:   mem_req_wmask = 4'b0011 << addr_q[1:0];
            default: mem_req_wmask = 4'b1111;
         endcase
      end
   end

   assign in_ready      = (state_q == S_IDLE);
   assign mem_req_valid = (state_q == S_REQ);
   assign mem_req_addr  = {addr_q[31:2], 2'b00};
   assign mem_req_wen   = store_q;
   assign out_valid     = (state_q == S_DONE);
   assign out_wb_data   = (load_q & ~mis_q) ? load_fmt : addr_q;
   assign out_rd_addr   = rd_q;
   assign out_reg_write = out_valid & regw_q & ~store_q & ~mis_q;
   assign out_misalign  = out_valid & mis_q;

endmodule

// File: tb/tb_ysyx_25040109_lsu.sv
// Bench for ysyx_25040109_lsu: directed cases plus random transactions checked
// against an arithmetic model of the load/store formatting rules.
module tb_ysyx_25040109_lsu;

   logic        clk, rst;
   logic        in_valid, in_ready, in_mem_ren, in_mem_wen, in_reg_write;
   logic [2:0]  in_funct3;
   logic [31:0] in_result, in_wdata;
   logic [4:0]  in_rd_addr;
   logic        out_valid, out_ready, out_reg_write, out_misalign;
   logic [31:0] out_wb_data;
   logic [4:0]  out_rd_addr;
   logic        mem_req_valid, mem_req_ready, mem_req_wen;
   logic [31:0] mem_req_addr, mem_req_wdata;
   logic [3:0]  mem_req_wmask;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_rdata;

   int n_chk = 0;
   int n_fail = 0;

   ysyx_25040109_lsu dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_mem_ren(in_mem_ren), .in_mem_wen(in_mem_wen), .in_funct3(in_funct3),
      .in_result(in_result), .in_wdata(in_wdata), .in_rd_addr(in_rd_addr),
      .in_reg_write(in_reg_write),
      .out_valid(out_valid), .out_ready(out_ready), .out_wb_data(out_wb_data),
      .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write), .out_misalign(out_misalign),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
      .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: access size from funct3, alignment by modulo, lanes by arithmetic.
   function automatic void model(input logic ren, wen, input logic [2:0] f3,
                                 input logic [31:0] a, wd, rdata, input logic rw,
                                 output logic ismem, store, mis, output logic [3:0] mask,
                                 output logic [31:0] wdat, wb, output logic regw);
      int sz, off;
      logic sgn;
      logic [31:0] v;
      case (f3)
         3'b000: begin sz = 1; sgn = 1'b1; end
         3'b001: begin sz = 2; sgn = 1'b1; end
         3'b100: begin sz = 1; sgn = 1'b0; end
         3'b101: begin sz = 2; sgn = 1'b0; end
         default: begin sz = 4; sgn = 1'b0; end
      endcase
      off   = int'(a[1:0]);
      store = wen;
      ismem = ren | wen;
      mis   = ismem && ((off % sz) != 0);
      mask  = (store && !mis) ? 4'(((1 << sz) - 1) << off) : 4'b0000;
      wdat  = (sz == 1) ? wd[7:0] * 32'h01010101 : (sz == 2) ? wd[15:0] * 32'h00010001 : wd;
      wb    = a;
      if (ren && !wen && !mis) begin
         v = rdata >> (8 * off);
         if (sz == 1) begin
            v = v & 32'hFF;
            if (sgn && v[7]) v = v | 32'hFFFFFF00;
         end else if (sz == 2) begin
            v = v & 32'hFFFF;
            if (sgn && v[15]) v = v | 32'hFFFF0000;
         end
         wb = v;
      end
      regw = rw && !store && !mis;
   endfunction

   // Drives one transaction end to end with stalls on both handshakes; checks inline.
   task automatic run_txn(input logic ren, wen, input logic [2:0] f3,
                          input logic [31:0] a, wd, rdata, input logic [4:0] rd,
                          input logic rw, input int req_dly, rsp_dly, out_dly,
                          output logic [31:0] o_wb, o_addr, o_wdata,
                          output logic [3:0] o_mask, output logic o_regw, o_mis, o_req);
      logic e_mem, e_store, e_mis, e_regw;
      logic [3:0] e_mask;
      logic [31:0] e_wdat, e_wb;
      model(ren, wen, f3, a, wd, rdata, rw, e_mem, e_store, e_mis, e_mask, e_wdat, e_wb, e_regw);
      o_addr = '0; o_wdata = '0; o_mask = '0;
      @(negedge clk);
      n_chk++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL in_ready_idle got=%b exp=1", in_ready); end
      in_valid = 1'b1; in_mem_ren = ren; in_mem_wen = wen; in_funct3 = f3;
      in_result = a; in_wdata = wd; in_rd_addr = rd; in_reg_write = rw;
      @(negedge clk);
      in_valid = 1'b0; in_result = $urandom; in_wdata = $urandom;
      in_rd_addr = 5'($urandom); in_funct3 = 3'($urandom);
      in_mem_ren = 1'($urandom); in_mem_wen = 1'($urandom); in_reg_write = 1'($urandom);
      o_req = mem_req_valid;
      if (e_mem && !e_mis) begin
         o_addr = mem_req_addr; o_wdata = mem_req_wdata; o_mask = mem_req_wmask;
         n_chk++;
         if (mem_req_valid !== 1'b1 || mem_req_addr !== {a[31:2], 2'b00} ||
             mem_req_wen !== e_store || mem_req_wmask !== e_mask ||
             (e_store && mem_req_wdata !== e_wdat)) begin
            n_fail++;
            $display("FAIL mem_req got v=%b a=%h wen=%b m=%b d=%h exp v=1 a=%h wen=%b m=%b d=%h",
                     mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask, mem_req_wdata,
                     {a[31:2], 2'b00}, e_store, e_mask, e_wdat);
         end
         for (int i = 0; i < req_dly; i++) begin
            @(negedge clk);
            n_chk++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== o_addr || mem_req_wdata !== o_wdata ||
                mem_req_wmask !== o_mask || in_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL req_hold got v=%b a=%h d=%h m=%b rdy=%b exp v=1 a=%h d=%h m=%b rdy=0",
                        mem_req_valid, mem_req_addr, mem_req_wdata, mem_req_wmask, in_ready,
                        o_addr, o_wdata, o_mask);
            end
         end
         mem_req_ready = 1'b1;
         @(negedge clk);
         mem_req_ready = 1'b0;
         for (int i = 0; i < rsp_dly; i++) begin
            @(negedge clk);
            n_chk++;
            if (out_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
               n_fail++;
               $display("FAIL wait_idle got ov=%b rv=%b exp 0 0", out_valid, mem_req_valid);
            end
         end
         mem_rsp_valid = 1'b1; mem_rsp_rdata = rdata;
         @(negedge clk);
         mem_rsp_valid = 1'b0; mem_rsp_rdata = $urandom;
      end else begin
         n_chk++;
         if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL no_mem_req got=%b exp=0", mem_req_valid); end
      end
      o_wb = out_wb_data; o_regw = out_reg_write; o_mis = out_misalign;
      n_chk++;
      if (out_valid !== 1'b1 || out_rd_addr !== rd || out_reg_write !== e_regw ||
          out_misalign !== e_mis || (!e_mis && out_wb_data !== e_wb)) begin
         n_fail++;
         $display("FAIL out got v=%b wb=%h rd=%0d rw=%b mis=%b exp v=1 wb=%h rd=%0d rw=%b mis=%b",
                  out_valid, out_wb_data, out_rd_addr, out_reg_write, out_misalign,
                  e_wb, rd, e_regw, e_mis);
      end
      for (int i = 0; i < out_dly; i++) begin
         @(negedge clk);
         n_chk++;
         if (out_valid !== 1'b1 || out_wb_data !== o_wb || out_rd_addr !== rd ||
             out_reg_write !== o_regw || out_misalign !== o_mis || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL out_hold got v=%b wb=%h rdy=%b exp v=1 wb=%h rdy=0",
                     out_valid, out_wb_data, in_ready, o_wb);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_chk++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL out_release got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_chk++;
      if (out_valid !== 1'b0 || mem_req_valid !== 1'b0 || out_reg_write !== 1'b0 ||
          out_misalign !== 1'b0 || out_wb_data !== 32'h0 || out_rd_addr !== 5'd0) begin
         n_fail++;
         $display("FAIL reset_outputs got ov=%b rv=%b rw=%b mis=%b wb=%h rd=%0d exp all 0",
                  out_valid, mem_req_valid, out_reg_write, out_misalign, out_wb_data, out_rd_addr);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_chk++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_directed();
      logic [31:0] wb, ad, wdt;
      logic [3:0] mk;
      logic rw, mis, req;
      run_txn(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 32'h0, 5'd5, 1'b1, 0, 0, 0,
              wb, ad, wdt, mk, rw, mis, req);
      n_chk++;
      if (wb !== 32'h1234 || rw !== 1'b1 || req !== 1'b0) begin
         n_fail++; $display("FAIL passthru got wb=%h rw=%b req=%b exp 1234 1 0", wb, rw, req);
      end
      run_txn(1'b1, 1'b0, 3'b000, 32'h80000003, 32'h0, 32'h80AABBCC, 5'd7, 1'b1, 0, 0, 0,
              wb, ad, wdt, mk, rw, mis, req);
      n_chk++;
      if (wb !== 32'hFFFFFF80 || ad !== 32'h80000000 || mk !== 4'b0000) begin
         n_fail++; $display("FAIL lb got wb=%h a=%h m=%b exp ffffff80 80000000 0000", wb, ad, mk);
      end
      run_txn(1'b1, 1'b0, 3'b100, 32'h80000003, 32'h0, 32'h80AABBCC, 5'd7, 1'b1, 0, 1, 0,
              wb, ad, wdt, mk, rw, mis, req);
      n_chk++;
      if (wb !== 32'h00000080) begin n_fail++; $display("FAIL lbu got wb=%h exp 00000080", wb); end
      run_txn(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000BEEF, 32'h0, 5'd9, 1'b1, 0, 0, 0,
              wb, ad, wdt, mk, rw, mis, req);
      n_chk++;
      if (mk !== 4'b1100 || wdt !== 32'hBEEFBEEF || rw !== 1'b0 || wb !== 32'h102) begin
         n_fail++; $display("FAIL sh got m=%b d=%h rw=%b wb=%h exp 1100 beefbeef 0 102", mk, wdt, rw, wb);
      end
      run_txn(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 5'd3, 1'b1, 0, 0, 0,
              wb, ad, wdt, mk, rw, mis, req);
      n_chk++;
      if (mis !== 1'b1 || rw !== 1'b0 || req !== 1'b0) begin
         n_fail++; $display("FAIL lw_misalign got mis=%b rw=%b req=%b exp 1 0 0", mis, rw, req);
      end
      // ren and wen together behave as a store; funct3 111 behaves as a word access
      run_txn(1'b1, 1'b1, 3'b111, 32'h200, 32'hCAFEF00D, 32'h12345678, 5'd4, 1'b1, 0, 0, 0,
              wb, ad, wdt, mk, rw, mis, req);
      n_chk++;
      if (mk !== 4'b1111 || wdt !== 32'hCAFEF00D || rw !== 1'b0) begin
         n_fail++; $display("FAIL both_en got m=%b d=%h rw=%b exp 1111 cafef00d 0", mk, wdt, rw);
      end
   endtask

   task automatic test_stall();
      logic [31:0] wb, ad, wdt;
      logic [3:0] mk;
      logic rw, mis, req;
      run_txn(1'b1, 1'b0, 3'b101, 32'h0000_0402, 32'h0, 32'h8001_7FFF, 5'd12, 1'b1, 3, 2, 2,
              wb, ad, wdt, mk, rw, mis, req);
      n_chk++;
      if (wb !== 32'h00008001) begin n_fail++; $display("FAIL lhu_stall got wb=%h exp 00008001", wb); end
   endtask

   task automatic test_random();
      logic [31:0] wb, ad, wdt;
      logic [3:0] mk;
      logic rw, mis, req, ren, wen;
      logic [2:0] f3;
      logic [2:0] st_codes [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b111};
      for (int t = 0; t < 60; t++) begin
         ren = 1'($urandom); wen = 1'($urandom);
         f3 = wen ? st_codes[$urandom_range(0, 5)] : 3'($urandom);
         run_txn(ren, wen, f3, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom),
                 $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2),
                 wb, ad, wdt, mk, rw, mis, req);
      end
   endtask

   task automatic test_reset_midflight();
      @(negedge clk);
      in_valid = 1'b1; in_mem_ren = 1'b1; in_mem_wen = 1'b0; in_funct3 = 3'b010;
      in_result = 32'h300; in_rd_addr = 5'd6; in_reg_write = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hDEADBEEF;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_chk++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_abandon got ov=%b rdy=%b rv=%b exp 0 1 0", out_valid, in_ready, mem_req_valid);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_mem_ren = 1'b0; in_mem_wen = 1'b0; in_funct3 = '0;
      in_result = '0; in_wdata = '0; in_rd_addr = '0; in_reg_write = 1'b0;
      out_ready = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
      test_reset();
      test_directed();
      test_stall();
      test_random();
      test_reset_midflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ysyx_25040109_lsu.md
YSYX_25040109_LSU -- requirements
Module: ysyx_25040109_LSU

Interface
REQ-001 SHALL: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL: in_valid/in_ready  in/out  1/1  upstream handshake from execute stage.
REQ-004 SHALL: in_mem_ren, in_mem_wen  in  1/1  load/store request; both low = pass-through.
REQ-005 SHALL: in_funct3  in  3  RISC-V width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-006 SHALL: in_result  in  32  ALU result, used as byte address when ren or wen is set.
REQ-007 SHALL: in_wdata  in  32  store data (rs2).
REQ-008 SHALL: in_rd_addr  in  5; in_reg_write  in  1  destination register and write enable.
REQ-009 SHALL: out_valid/out_ready  out/in  1/1  downstream handshake to write-back stage.
REQ-010 SHALL: out_wb_data  out  32; out_rd_addr  out  5; out_reg_write  out  1.
REQ-011 SHALL: out_misalign  out  1  high with out_valid when the access was misaligned.
REQ-012 SHALL: mem_req_valid/mem_req_ready  out/in  1/1  memory request handshake.
REQ-013 SHALL: mem_req_addr  out  32  word-aligned (addr[1:0]=00); mem_req_wen  out  1; mem_req_wdata  out  32; mem_req_wmask  out  4.
REQ-014 SHALL: mem_rsp_valid  in  1; mem_rsp_rdata  in  32  single-cycle response pulse; acknowledges stores too.

Function
REQ-015 SHALL: FSM states IDLE, REQ, WAIT, DONE; in_ready=1 only in IDLE.
REQ-016 SHALL: on in_valid&in_ready, register all inputs; next state is DONE for pass-through or misaligned accesses, otherwise REQ.
REQ-017 SHALL: misaligned = LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=00; no memory request is issued; out_reg_write=0, out_misalign=1.
REQ-018 SHALL: REQ drives mem_req_valid=1 with stable address/data/mask until mem_req_ready; transition to WAIT on that handshake cycle.
REQ-019 SHALL: WAIT moves to DONE on mem_rsp_valid; rdata captured that cycle; mem_rsp_valid outside WAIT is ignored.
REQ-020 SHALL: DONE drives out_valid=1, holding every output stable until out_ready; on out_valid&out_ready return to IDLE (no back-to-back accept in the same cycle).
REQ-021 SHALL: latency from accept edge: pass-through/misaligned out_valid 1 cycle later; memory ops out_valid 1 cycle after the mem_rsp_valid cycle.
REQ-022 SHALL: store mask: SB 0001<<addr[1:0]; SH 0011<<addr[1:0]; SW 1111; wdata byte-replicated for SB, halfword-replicated for SH.
REQ-023 SHALL: load data selected by addr[1:0]; LB/LH sign-extended, LBU/LHU zero-extended, LW unmodified.
REQ-024 SHALL: out_wb_data = formatted load data for loads, in_result for pass-through and stores; out_reg_write = in_reg_write for loads/pass-through, 0 for stores and misaligned ops.
REQ-025 SHALL: out_rd_addr = registered in_rd_addr in all cases.
REQ-026 SHALL: in_mem_ren and in_mem_wen both set is treated as a store.
REQ-027 SHALL: funct3 codes 011, 110, 111 with ren/wen set are handled as LW/SW.

Reset
REQ-028 SHALL: rst forces IDLE; in_ready=1 (once rst deasserts); out_valid, mem_req_valid, out_reg_write, out_misalign = 0; data registers = 0.
REQ-029 SHALL: reset mid-transaction abandons it; a later mem_rsp_valid arriving in IDLE is ignored and produces no output.

Verification
REQ-030 SHALL: pass-through, in_result=0x1234, rd=5, reg_write=1 -> out_valid 1 cycle later, wb_data=0x1234, rd=5, no mem_req_valid.
REQ-031 SHALL: LB addr=0x80000003, rdata=0x80AABBCC, ready=1 -> mem_req_addr=0x80000000, wmask=0, wb_data=0xFFFFFF80; LBU same -> 0x00000080.
REQ-032 SHALL: SH addr=0x102, wdata=0x0000BEEF -> wmask=1100, mem_req_wdata=0xBEEFBEEF, wen=1, out_reg_write=0.
REQ-033 SHALL: LW addr=0x101 -> no memory request, out_valid next cycle with out_misalign=1, out_reg_write=0.
REQ-034 SHALL: mem_req_ready low 3 cycles and out_ready low 2 cycles -> request and outputs held stable, in_ready=0 throughout.
REQ-035 SHALL: rst asserted in WAIT, then mem_rsp_valid pulsed -> out_valid stays 0, in_ready=1.
